// File: rtl/ahb_sram_slave_pkg.sv
// Shared AHB-Lite encodings and the responder FSM state set.
package ahb_sram_slave_pkg;

    typedef enum logic [1:0] {
        TRANS_IDLE   = 2'b00,
        TRANS_BUSY   = 2'b01,
        TRANS_NONSEQ = 2'b10,
        TRANS_SEQ    = 2'b11
    } trans_e;

    typedef enum logic [2:0] {
        SIZE_BYTE = 3'b000,
        SIZE_HALF = 3'b001,
        SIZE_WORD = 3'b010
    } size_e;

    typedef enum logic [2:0] {
        BURST_SINGLE = 3'b000,
        BURST_INCR   = 3'b001,
        BURST_WRAP4  = 3'b010,
        BURST_INCR4  = 3'b011,
        BURST_WRAP8  = 3'b100,
        BURST_INCR8  = 3'b101,
        BURST_WRAP16 = 3'b110,
        BURST_INCR16 = 3'b111
    } burst_e;

    typedef enum logic [1:0] {
        RESP_OKAY  = 2'b00,
        RESP_ERROR = 2'b01
    } resp_e;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WR_DATA  = 3'd1,
        ST_RD_DATA  = 3'd2,
        ST_RD_STALL = 3'd3,
        ST_ERR1     = 3'd4,
        ST_ERR2     = 3'd5
    } state_e;

    // NONSEQ and SEQ both carry a real transfer; IDLE and BUSY do not.
    function automatic logic trans_active(input logic [1:0] trans);
        return trans[1];
    endfunction

endpackage

// File: rtl/ahb_sram_slave_if.sv
// AHB-Lite slave-side bus bundle between the decoder/master and the responder.
interface ahb_sram_slave_if;
    logic        sel;
    logic [31:0] addr;
    logic        write;
    logic [1:0]  trans;
    logic [2:0]  size;
    logic [2:0]  burst;
    logic [31:0] wdata;
    logic        readyi;
    logic        readyo;
    logic [1:0]  resp;
    logic [31:0] rdata;

    modport master (
        output sel, addr, write, trans, size, burst, wdata, readyi,
        input  readyo, resp, rdata
    );

    modport slave (
        input  sel, addr, write, trans, size, burst, wdata, readyi,
        output readyo, resp, rdata
    );
endinterface

// File: rtl/ahb_sram_slave_bectl.sv
// Maps transfer size and low address bits to SRAM byte enables and an
// alignment fault (oversized transfers are reported as faults too).
module ahb_sram_slave_bectl
    import ahb_sram_slave_pkg::*;
(
    input  logic [2:0] size,
    input  logic [1:0] addr_lo,
    output logic [3:0] be,
    output logic       err_align
);

    // Lane decode and alignment check for one address phase
    always_comb begin
        be        = 4'b0000;
        err_align = 1'b0;
        case (size)
            SIZE_BYTE: begin
                be = 4'b0001 << addr_lo;
            end
            SIZE_HALF: begin
                be        = addr_lo[1] ? 4'b1100 : 4'b0011;
                err_align = addr_lo[0];
            end
            SIZE_WORD: begin
                be        = 4'b1111;
                err_align = |addr_lo;
            end
            default: begin
                be        = 4'b0000;
                err_align = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite responder in front of a single-port synchronous 32-bit SRAM.
// Reads issue combinationally in the address phase (zero wait); writes issue
// in the data phase, so a read right behind a write is stalled one cycle.
module ahb_sram_slave
    import ahb_sram_slave_pkg::*;
#(
    parameter int SRAM_AW = 12
) (
    input  logic               hclk,
    input  logic               rst,
    ahb_sram_slave_if.slave    ahb,
    output logic               sram_cs,
    output logic               sram_we,
    output logic [3:0]         sram_be,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [31:0]        sram_wdata,
    input  logic [31:0]        sram_rdata
);

    state_e             state_r, state_nx_s;
    logic [SRAM_AW-1:0] addr_r, addr_nx_s;
    logic [3:0]         be_r, be_nx_s, be_s;
    logic               err_align_s, err_range_s, err_s;
    logic               ready_s, accept_s;
    logic               cs_s, we_s;
    logic [3:0]         sram_be_s;
    logic [SRAM_AW-1:0] sram_addr_s;
    logic [31:0]        sram_wdata_s, rdata_s;
    logic [1:0]         resp_s;
    logic               burst_unused_s;

    ahb_sram_slave_bectl u_bectl (
        .size      (ahb.size),
        .addr_lo   (ahb.addr[1:0]),
        .be        (be_s),
        .err_align (err_align_s)
    );

    // Only the stall and first error cycle hold the bus; they never sample a new address phase.
    assign ready_s        = (state_r != ST_RD_STALL) && (state_r != ST_ERR1);
    assign accept_s       = ahb.sel & trans_active(ahb.trans) & ahb.readyi & ready_s;
    assign err_range_s    = |ahb.addr[31:SRAM_AW+2];
    assign err_s          = err_align_s | err_range_s;
    assign burst_unused_s = ^ahb.burst;

    // Next state, latched address-phase info and raw SRAM/bus outputs
    always_comb begin
        state_nx_s   = state_r;
        addr_nx_s    = addr_r;
        be_nx_s      = be_r;
        resp_s       = RESP_OKAY;
        rdata_s      = 32'h0000_0000;
        cs_s         = 1'b0;
        we_s         = 1'b0;
        sram_be_s    = 4'b0000;
        sram_addr_s  = '0;
        sram_wdata_s = 32'h0000_0000;

        case (state_r)
            ST_IDLE: begin
                state_nx_s = ST_IDLE;
            end
            ST_WR_DATA: begin
                cs_s         = 1'b1;
                we_s         = 1'b1;
                sram_be_s    = be_r;
                sram_addr_s  = addr_r;
                sram_wdata_s = ahb.wdata;
            end
            ST_RD_DATA: begin
                rdata_s = sram_rdata;
            end
            ST_RD_STALL: begin
                cs_s        = 1'b1;
                sram_addr_s = addr_r;
                state_nx_s  = ST_RD_DATA;
            end
            ST_ERR1: begin
                resp_s     = RESP_ERROR;
                state_nx_s = ST_ERR2;
            end
            ST_ERR2: begin
                resp_s = RESP_ERROR;
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase

        // The data phase is completing, so the address phase decides what comes next.
        if (ready_s) begin
            if (!accept_s) begin
                state_nx_s = ST_IDLE;
            end else if (err_s) begin
                state_nx_s = ST_ERR1;
            end else if (ahb.write) begin
                addr_nx_s  = ahb.addr[SRAM_AW+1:2];
                be_nx_s    = be_s;
                state_nx_s = ST_WR_DATA;
            end else if (state_r == ST_WR_DATA) begin
                // SRAM port is busy with the write: park the read for one cycle
                addr_nx_s  = ahb.addr[SRAM_AW+1:2];
                state_nx_s = ST_RD_STALL;
            end else begin
                cs_s        = 1'b1;
                we_s        = 1'b0;
                sram_addr_s = ahb.addr[SRAM_AW+1:2];
                state_nx_s  = ST_RD_DATA;
            end
        end else begin
            addr_nx_s = addr_r;
        end
    end

    // Reset forces every output to its idle value, which also drops a write in flight
    always_comb begin
        if (rst) begin
            ahb.readyo = 1'b1;
            ahb.resp   = RESP_OKAY;
            ahb.rdata  = 32'h0000_0000;
            sram_cs    = 1'b0;
            sram_we    = 1'b0;
            sram_be    = 4'b0000;
            sram_addr  = '0;
            sram_wdata = 32'h0000_0000;
        end else begin
            ahb.readyo = ready_s;
            ahb.resp   = resp_s;
            ahb.rdata  = rdata_s;
            sram_cs    = cs_s;
            sram_we    = we_s;
            sram_be    = sram_be_s;
            sram_addr  = sram_addr_s;
            sram_wdata = sram_wdata_s;
        end
    end

    // State and latched address-phase registers
    always_ff @(posedge hclk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            addr_r  <= '0;
            be_r    <= 4'b0000;
        end else begin
            state_r <= state_nx_s;
            addr_r  <= addr_nx_s;
            be_r    <= be_nx_s;
        end
    end

endmodule

// File: doc/ahb_sram_slave.md
Name: ahb_sram_slave

Overview:
AHB-Lite responder that bridges AHB transfers to a single-port synchronous 32-bit SRAM. It is the target-side counterpart of the AHB master bus-functional model used in the ahb2sram benches, and sits between the AHB decoder (ahb_sel) and the SRAM macro. It supports byte, halfword and word accesses, zero-wait reads, single-cycle writes and a two-cycle ERROR response. A read that immediately follows a write takes one wait state.

Parameters:
SRAM_AW, 12, SRAM word-address width; capacity is 4*2^SRAM_AW bytes.
DLY, 1, simulation-only delay on register assignments; no functional effect.

Ports:
hclk  in  1  bus clock; all logic on rising edge
rst  in  1  synchronous reset, active-high
ahb_sel  in  1  slave select from decoder
ahb_addr  in  32  address-phase address
ahb_write  in  1  1=write, 0=read
ahb_trans  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
ahb_size  in  3  BYTE=000, HALF=001, WORD=010
ahb_burst  in  3  burst type; accepted but not used
ahb_wdata  in  32  data-phase write data
ahb_readyi  in  1  bus HREADY; qualifies the address phase
ahb_readyo  out  1  slave HREADYOUT
ahb_resp  out  2  OKAY=00, ERROR=01
ahb_rdata  out  32  read data
sram_cs  out  1  SRAM chip select
sram_we  out  1  SRAM write enable
sram_be  out  4  byte enables; bit n covers lane [8n+7:8n]
sram_addr  out  SRAM_AW  SRAM word address
sram_wdata  out  32  SRAM write data
sram_rdata  in  32  SRAM read data; valid the cycle after a cs=1, we=0 access

Behaviour:
- Accept condition: ahb_sel & ahb_trans[1] & ahb_readyi. IDLE/BUSY or unselected transfers get OKAY with zero wait and no SRAM access. SEQ is handled exactly like NONSEQ; each beat uses the address the master presents.
- Error check on an accepted transfer:
  - size > WORD → ERROR
  - HALF with addr[0]=1 → ERROR
  - WORD with addr[1:0]≠0 → ERROR
  - any bit of ahb_addr[31:SRAM_AW+2] set → ERROR
- FSM states are IDLE, WR_DATA, RD_DATA, RD_STALL, ERR1 and ERR2.
- IDLE / any state whose data phase is completing with readyo=1:
  - Accepted error → ERR1.
  - Accepted write → latch address and size, go to WR_DATA.
  - Accepted read with no write in the current data phase → drive cs=1, we=0, addr=ahb_addr[SRAM_AW+1:2] combinationally, go to RD_DATA.
- WR_DATA:
  - SRAM outputs: cs=1, we=1, addr=latched, wdata=ahb_wdata, be derived from latched size and addr[1:0].
  - Bus outputs: readyo=1, resp=OKAY.
  - A read accepted in this cycle is latched and goes to RD_STALL (port conflict). A write accepted here goes to WR_DATA; an error goes to ERR1.
- RD_STALL: cs=1, we=0 at the latched read address; readyo=0; next state RD_DATA.
- RD_DATA: ahb_rdata=sram_rdata, readyo=1, resp=OKAY. Pipelined reads in this cycle proceed with zero wait.
- ERR1: readyo=0, resp=ERROR, no SRAM access; next state ERR2.
- ERR2: readyo=1, resp=ERROR. The address phase is sampled normally; the master may issue IDLE here.
- Byte enables:
  - BYTE: 1<<addr[1:0]
  - HALF: addr[1] ? 1100 : 0011
  - WORD: 1111
- Data lanes are little-endian and written unshifted; ahb_rdata always returns the full word.
- ahb_rdata=0 outside RD_DATA.
- Read-after-write to the same address returns the new data, because the write completes before the stalled read is issued.
- ahb_sel or ahb_trans changes while readyo=0 are ignored.
- Reset, synchronous, asserted: state=IDLE, readyo=1, resp=OKAY, rdata=0, cs=0, we=0, be=0, sram_addr=0, sram_wdata=0.
- Reset in the WR_DATA cycle suppresses that write: cs is gated by !rst. Reset in ERR1/RD_STALL aborts the transfer without completion.

Decomposition:
- ahb_pkg holds the trans/size/burst/resp encodings and the FSM state enum; these are shared with the master BFM.
- One combinational sub-module, ahb_sram_bectl, maps (size, addr[1:0]) to {be[3:0], err_align}.

Test Plan:
- Reset, then a write of 0xDEADBEEF to 0x10 and a read of 0x10: sram_be=1111 and sram_addr=4; read returns 0xDEADBEEF with zero wait; resp=OKAY on both.
- Byte writes 0x11, 0x22, 0x33, 0x44 to 0x20..0x23, then a word read of 0x20: be sequence 0001, 0010, 0100, 1000; read returns 0x44332211.
- Write 0xA5A5A5A5 to 0x40 immediately followed by a read of 0x40: readyo low for exactly one cycle (RD_STALL); rdata=0xA5A5A5A5.
- INCR4 read of 0x100..0x10C after preloading words 1..4: four consecutive readyo=1 beats returning 1, 2, 3, 4.
- WORD read at 0x2 and a write to 0x4000 with SRAM_AW=12: each gives readyo 0 then 1 with resp=ERROR both cycles; sram_cs never asserted.
- Assert rst in the WR_DATA cycle of a write of 0xFFFFFFFF to 0x8: cs stays 0; a later read of 0x8 returns the preloaded old value; all outputs are at reset values the cycle after reset.
